// File: rtl/ilm_ecc_scrubber.sv
// Background SECDED scrubber: reads every ILM word, corrects single-bit errors by write-back, counts/flags double-bit errors.
// Latency (gnt tied high): 1 start cycle + 3 cycles per clean/DED word + 4 per corrected word + 1 DONE cycle.
// Backpressure: ram_req is held until ram_gnt; abort ends the pass only from RD (no grant yet) or after a word completes, never mid write-back.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   start, abort    start pulse (ignored while busy), abort level
//   ram_req/gnt/we/addr/wdata/rdata   single SRAM access port; rdata valid the cycle after a read transfer
//   busy, done      pass in progress / one-cycle end-of-pass pulse
//   sec_cnt, ded_cnt, ded_flag, ded_addr   saturating error counters, first uncorrectable error of the pass
module ilm_ecc_scrubber #(
    parameter int AW    = 10,
    parameter int DEPTH = 1024,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             ram_req,
    input  logic             ram_gnt,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [39:0]      ram_wdata,
    input  logic [39:0]      ram_rdata,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sec_cnt,
    output logic [CNT_W-1:0] ded_cnt,
    output logic             ded_flag,
    output logic [AW-1:0]    ded_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_CHK,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    // Spread data and check bits over Hamming positions 1..38; check bit k
    // lives at position 2^k, data fills the remaining positions in order.
    function automatic logic [38:0] to_cw(input logic [31:0] d, input logic [5:0] ck);
        logic [38:0] cw;
        int          di;
        int          ki;
        cw = '0;
        di = 0;
        ki = 0;
        for (int j = 1; j <= 38; j++) begin
            if ((j & (j - 1)) == 0) begin
                cw[j[5:0]] = ck[ki[2:0]];
                ki++;
            end else begin
                cw[j[5:0]] = d[di[4:0]];
                di++;
            end
        end
        return cw;
    endfunction

    function automatic logic [31:0] from_cw(input logic [38:0] cw);
        logic [31:0] d;
        int          di;
        d  = '0;
        di = 0;
        for (int j = 3; j <= 38; j++) begin
            if ((j & (j - 1)) != 0) begin
                d[di[4:0]] = cw[j[5:0]];
                di++;
            end
        end
        return d;
    endfunction

    // XOR of every position that has bit k set. With the stored check bits
    // in place this is the syndrome; with them zeroed it is the fresh code.
    function automatic logic [5:0] syndrome(input logic [38:0] cw);
        logic [5:0] s;
        s = '0;
        for (int j = 1; j <= 38; j++) begin
            for (int k = 0; k < 6; k++) begin
                if (((j >> k) & 1) == 1) begin
                    s[k[2:0]] = s[k[2:0]] ^ cw[j[5:0]];
                end
            end
        end
        return s;
    endfunction

    function automatic logic [6:0] gen_ecc(input logic [31:0] d);
        logic [5:0] c;
        c = syndrome(to_cw(d, 6'b0));
        return {(^d) ^ (^c), c};
    endfunction

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [38:0]      rdata_q, rdata_d;
    logic [39:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [CNT_W-1:0] ded_cnt_q, ded_cnt_d;
    logic             ded_flag_q, ded_flag_d;
    logic [AW-1:0]    ded_addr_q, ded_addr_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Bit 39 of the stored word carries no information.
    logic unused_rdata_b39;
    assign unused_rdata_b39 = ram_rdata[39];

    // Decode of the captured word.
    logic [38:0] cw;
    logic [38:0] fix_cw;
    logic [5:0]  syn;
    logic        par;
    logic        is_sec;
    logic        is_ded;
    logic [31:0] fix_data;
    logic [6:0]  fix_ecc;

    always_comb begin
        cw     = to_cw(rdata_q[31:0], rdata_q[37:32]);
        syn    = syndrome(cw);
        par    = ^rdata_q[38:0];
        // Odd parity with s == 0 means c6 itself flipped: data is intact,
        // but the word is still rewritten with a fresh code.
        is_sec = par && (syn <= 6'd38);
        is_ded = (par && (syn > 6'd38)) || (!par && (syn != 6'd0));
        fix_cw = cw;
        if (is_sec && (syn != 6'd0)) begin
            fix_cw = cw ^ (39'(1) << syn);
        end
        fix_data = from_cw(fix_cw);
        fix_ecc  = gen_ecc(fix_data);
    end

    logic advance;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        wdata_d    = wdata_q;
        sec_cnt_d  = sec_cnt_q;
        ded_cnt_d  = ded_cnt_q;
        ded_flag_d = ded_flag_q;
        ded_addr_d = ded_addr_q;
        advance    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sec_cnt_d  = '0;
                    ded_cnt_d  = '0;
                    ded_flag_d = 1'b0;
                    ded_addr_d = '0;
                    addr_d     = '0;
                    state_d    = S_RD;
                end
            end
            S_RD: begin
                // A granted read must complete, so abort only wins without gnt.
                if (ram_gnt) begin
                    state_d = S_WAIT;
                end else if (abort) begin
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                rdata_d = ram_rdata[38:0];
                state_d = S_CHK;
            end
            S_CHK: begin
                if (is_sec) begin
                    if (sec_cnt_q != '1) begin
                        sec_cnt_d = sec_cnt_q + CNT_W'(1);
                    end
                    wdata_d = {1'b0, fix_ecc, fix_data};
                    state_d = S_WB;
                end else begin
                    if (is_ded) begin
                        if (ded_cnt_q != '1) begin
                            ded_cnt_d = ded_cnt_q + CNT_W'(1);
                        end
                        if (!ded_flag_q) begin
                            ded_flag_d = 1'b1;
                            ded_addr_d = addr_q;
                        end
                    end
                    advance = 1'b1;
                end
            end
            S_WB: begin
                // abort deliberately not looked at until the write is granted.
                if (ram_gnt) begin
                    advance = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Move to the next word in the same cycle the current one finishes.
        if (advance) begin
            if ((addr_q == LAST_ADDR) || abort) begin
                state_d = S_DONE;
            end else begin
                addr_d  = addr_q + AW'(1);
                state_d = S_RD;
            end
        end

        // Outputs are registered versions of the next state.
        req_d  = (state_d == S_RD) || (state_d == S_WB);
        we_d   = (state_d == S_WB);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rdata_q    <= '0;
            wdata_q    <= '0;
            sec_cnt_q  <= '0;
            ded_cnt_q  <= '0;
            ded_flag_q <= 1'b0;
            ded_addr_q <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            wdata_q    <= wdata_d;
            sec_cnt_q  <= sec_cnt_d;
            ded_cnt_q  <= ded_cnt_d;
            ded_flag_q <= ded_flag_d;
            ded_addr_q <= ded_addr_d;
            req_q      <= req_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ram_req   = req_q;
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sec_cnt   = sec_cnt_q;
    assign ded_cnt   = ded_cnt_q;
    assign ded_flag  = ded_flag_q;
    assign ded_addr  = ded_addr_q;

endmodule

// File: tb/tb_ilm_ecc_scrubber.sv
// Bench for ilm_ecc_scrubber: small 4-word memory, 2-bit counters so saturation is reachable.
module tb_ilm_ecc_scrubber;

    localparam int AW    = 3;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             ram_gnt = 1'b1;
    logic             ram_req;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [39:0]      ram_wdata;
    logic [39:0]      ram_rdata = '0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sec_cnt;
    logic [CNT_W-1:0] ded_cnt;
    logic             ded_flag;
    logic [AW-1:0]    ded_addr;

    int n_checks = 0;
    int n_errors = 0;

    logic [39:0]   mem [DEPTH];
    logic          rd_pend = 1'b0;
    logic [AW-1:0] rd_pend_addr = '0;

    typedef struct {
        logic [AW-1:0] a;
        logic [39:0]   d;
    } wr_t;

    wr_t           wq[$];
    logic [AW-1:0] rq[$];

    typedef struct {
        string                  name;
        logic [DEPTH-1:0][39:0] img;
        logic [DEPTH-1:0]       wr_mask;
        logic [DEPTH-1:0][39:0] wexp;
        int                     sec;
        int                     ded;
        logic                   flag;
        logic [AW-1:0]          daddr;
        int                     done_cyc;
        bit                     restart;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    ilm_ecc_scrubber #(.AW(AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .ram_req   (ram_req),
        .ram_gnt   (ram_gnt),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy),
        .done      (done),
        .sec_cnt   (sec_cnt),
        .ded_cnt   (ded_cnt),
        .ded_flag  (ded_flag),
        .ded_addr  (ded_addr)
    );

    // Read data appears only in the cycle after the read transfer; garbage otherwise.
    always @(posedge clk) begin
        if (rd_pend) ram_rdata <= mem[rd_pend_addr];
        else         ram_rdata <= {8'($urandom), 32'($urandom)};
    end

    // Reference encoder: data bit i sits at the i-th non-power-of-two position.
    function automatic logic [39:0] enc(input logic [31:0] d);
        int         pos [32];
        int         p;
        logic [5:0] ck;
        p = 2;
        for (int i = 0; i < 32; i++) begin
            p++;
            while ((p & (p - 1)) == 0) p++;
            pos[i] = p;
        end
        ck = '0;
        for (int k = 0; k < 6; k++)
            for (int i = 0; i < 32; i++)
                if (((pos[i] >> k) & 1) == 1) ck[k] = ck[k] ^ d[i];
        return {1'b0, (^d) ^ (^ck), ck, d};
    endfunction

    function automatic vec_t mk(input string n,
                                input logic [39:0] w0, input logic [39:0] w1,
                                input logic [39:0] w2, input logic [39:0] w3,
                                input logic [3:0] m,
                                input logic [39:0] x1, input logic [39:0] x2,
                                input int s, input int dd, input logic f,
                                input logic [AW-1:0] da, input int dc, input bit rs);
        vec_t v;
        v.name = n;
        v.img[0] = w0; v.img[1] = w1; v.img[2] = w2; v.img[3] = w3;
        v.wr_mask = m;
        v.wexp[0] = 40'h0; v.wexp[1] = x1; v.wexp[2] = x2; v.wexp[3] = 40'h0;
        v.sec = s; v.ded = dd; v.flag = f; v.daddr = da;
        v.done_cyc = dc; v.restart = rs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string msg);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Transfer monitor: checks every read/write against the scoreboard queues.
    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            #1;
            rd_pend = 1'b0;
            if (ram_req && ram_gnt) begin
                if (ram_we) begin
                    if (wq.size() == 0) begin
                        fail("unexpected_write", $sformatf("addr %0d data %0h, expected no write", ram_addr, ram_wdata));
                    end else begin
                        e = wq.pop_front();
                        chk("wr_addr", 64'(ram_addr), 64'(e.a));
                        chk("wr_data", 64'(ram_wdata), 64'(e.d));
                    end
                end else begin
                    rd_pend      = 1'b1;
                    rd_pend_addr = ram_addr;
                    if (rq.size() == 0)
                        fail("unexpected_read", $sformatf("addr %0d, expected no read", ram_addr));
                    else
                        chk("rd_addr", 64'(ram_addr), 64'(rq.pop_front()));
                end
            end
        end
    endtask

    task automatic check_end(input vec_t v);
        chk({v.name, ".sec_cnt"},  64'(sec_cnt),  64'(v.sec));
        chk({v.name, ".ded_cnt"},  64'(ded_cnt),  64'(v.ded));
        chk({v.name, ".ded_flag"}, 64'(ded_flag), 64'(v.flag));
        chk({v.name, ".ded_addr"}, 64'(ded_addr), 64'(v.daddr));
        chk({v.name, ".reads_left"},  64'(rq.size()), 64'd0);
        chk({v.name, ".writes_left"}, 64'(wq.size()), 64'd0);
        rq.delete();
        wq.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        int busy_low;
        bit seen;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = v.img[i];
            rq.push_back(AW'(i));
            if (v.wr_mask[i]) wq.push_back('{a: AW'(i), d: v.wexp[i]});
        end
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        busy_low = 0;
        seen = 1'b0;
        while (!seen && cyc < 80) begin
            @(negedge clk);
            cyc++;
            start = v.restart && (cyc == 5);
            if (!busy) busy_low++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk({v.name, ".busy_low_in_pass"}, 64'(busy_low), 64'd0);
        if (!seen) fail({v.name, ".done"}, "no done within 80 cycles, expected one");
        else       chk({v.name, ".done_cyc"}, 64'(cyc), 64'(v.done_cyc));
        @(negedge clk);
        chk({v.name, ".done_after"}, 64'(done), 64'd0);
        chk({v.name, ".busy_after"}, 64'(busy), 64'd0);
        check_end(v);
    endtask

    initial begin
        int   cyc;
        int   bad;
        vec_t v;

        fork
            monitor();
        join_none

        tbl[0] = mk("all_zero", 40'h0, 40'h0, 40'h0, 40'h0, 4'b0000, 40'h0, 40'h0,
                    0, 0, 1'b0, 3'd0, 13, 1'b0);
        tbl[1] = mk("sec_d5_w2", 40'h0, 40'h0, 40'h00_0000_0020, 40'h0, 4'b0100, 40'h0, 40'h0,
                    1, 0, 1'b0, 3'd0, 14, 1'b1);
        tbl[2] = mk("sec_c6_w1", 40'h0, 40'h40_0000_0000, 40'h0, 40'h0, 4'b0010, 40'h0, 40'h0,
                    1, 0, 1'b0, 3'd0, 14, 1'b0);
        tbl[3] = mk("sec_data", enc(32'h1234_5678), enc(32'hDEAD_BEEF) ^ 40'h00_0002_0000,
                    enc(32'h0F0F_00FF) ^ 40'h08_0000_0000, enc(32'hCAFE_F00D) | 40'h80_0000_0000,
                    4'b0110, enc(32'hDEAD_BEEF), enc(32'h0F0F_00FF),
                    2, 0, 1'b0, 3'd0, 15, 1'b0);
        tbl[4] = mk("ded_sat", 40'h3, 40'h3, 40'h3, 40'h3, 4'b0000, 40'h0, 40'h0,
                    0, 3, 1'b1, 3'd0, 13, 1'b0);
        tbl[5] = mk("ded_s_gt_38", 40'h6, 40'h0, 40'h0, 40'h20_0000_0014, 4'b0000, 40'h0, 40'h0,
                    0, 2, 1'b1, 3'd0, 13, 1'b0);
        tbl[6] = mk("ded_w1_w3", 40'h0, 40'h3, 40'h0, 40'h5, 4'b0000, 40'h0, 40'h0,
                    0, 2, 1'b1, 3'd1, 13, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.busy",     64'(busy),      64'd0);
        chk("rst.done",     64'(done),      64'd0);
        chk("rst.ram_req",  64'(ram_req),   64'd0);
        chk("rst.ram_we",   64'(ram_we),    64'd0);
        chk("rst.ram_addr", 64'(ram_addr),  64'd0);
        chk("rst.wdata",    64'(ram_wdata), 64'd0);
        chk("rst.sec_cnt",  64'(sec_cnt),   64'd0);
        chk("rst.ded_cnt",  64'(ded_cnt),   64'd0);
        chk("rst.ded_flag", 64'(ded_flag),  64'd0);
        chk("rst.ded_addr", 64'(ded_addr),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Abort in RD with no grant: no transfer, done two cycles after start; start clears flag/addr.
        ram_gnt = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk("abort_rd.done_cyc", 64'(cyc), 64'd2);
        abort = 1'b0;
        ram_gnt = 1'b1;
        @(negedge clk);
        chk("abort_rd.busy_after", 64'(busy), 64'd0);
        check_end(mk("abort_rd", 40'h0, 40'h0, 40'h0, 40'h0, 4'b0000, 40'h0, 40'h0,
                     0, 0, 1'b0, 3'd0, 0, 1'b0));

        // Abort during a stalled write-back: the write still lands, word 1 is never read.
        mem[0] = 40'h1; mem[1] = 40'h0; mem[2] = 40'h0; mem[3] = 40'h0;
        rq.push_back(3'd0);
        wq.push_back('{a: 3'd0, d: 40'h0});
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (!(ram_req && ram_we) && cyc < 20) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk("abort_wb.wb_cyc", 64'(cyc), 64'd4);
        ram_gnt = 1'b0;
        abort = 1'b1;
        bad = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (!(ram_req && ram_we)) bad++;
            if (i == 5) ram_gnt = 1'b1;
        end
        chk("abort_wb.req_held", 64'(bad), 64'd0);
        @(negedge clk);
        chk("abort_wb.done", 64'(done), 64'd1);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_wb.busy_after", 64'(busy), 64'd0);
        check_end(mk("abort_wb", 40'h0, 40'h0, 40'h0, 40'h0, 4'b0000, 40'h0, 40'h0,
                     1, 0, 1'b0, 3'd0, 0, 1'b0));

        // Reset during WAIT of word 2, then a fresh pass from address 0.
        v = mk("rescrub", 40'h3, 40'h00_0000_0020, 40'h0, 40'h0, 4'b0010, 40'h0, 40'h0,
               1, 1, 1'b1, 3'd0, 14, 1'b0);
        for (int i = 0; i < DEPTH; i++) mem[i] = v.img[i];
        rq.push_back(3'd0); rq.push_back(3'd1); rq.push_back(3'd2);
        wq.push_back('{a: 3'd1, d: 40'h0});
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (!(ram_req && !ram_we && ram_addr == 3'd2) && cyc < 30) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk("rst_mid.rd2_cyc", 64'(cyc), 64'd8);
        @(negedge clk);
        chk("rst_mid.pre_sec", 64'(sec_cnt), 64'd1);
        chk("rst_mid.pre_ded", 64'(ded_cnt), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.busy",    64'(busy),    64'd0);
        chk("rst_mid.ram_req", 64'(ram_req), 64'd0);
        chk("rst_mid.done",    64'(done),    64'd0);
        check_end(mk("rst_mid", 40'h0, 40'h0, 40'h0, 40'h0, 4'b0000, 40'h0, 40'h0,
                     0, 0, 1'b0, 3'd0, 0, 1'b0));
        @(negedge clk);
        run_vec(v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
